// File: rtl/mem_slave_pipe_if.sv
// mem_slave_pipe_if: request/response bus between a memory master and mem_slave_pipe
interface mem_slave_pipe_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
);
    logic                    req;
    logic                    req_ready;
    logic                    wr;
    logic [ADDR_WIDTH-1:0]   addr;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] be;
    logic                    slv_rsp;
    logic                    rsp_ready;
    logic                    rsp_wr;
    logic [DATA_WIDTH-1:0]   rdata;
    logic                    err;
    modport master (
        output req, wr, addr, wdata, be, rsp_ready,
        input  req_ready, slv_rsp, rsp_wr, rdata, err
    );
    modport slave (
        input  req, wr, addr, wdata, be, rsp_ready,
        output req_ready, slv_rsp, rsp_wr, rdata, err
    );
endinterface

// File: rtl/mem_slave_pipe.sv
// mem_slave_pipe: byte-enabled memory slave with in-order pipelined responses and back-pressure
module mem_slave_pipe #(
    parameter int ADDR_WIDTH   = 8,
    parameter int DATA_WIDTH   = 32,
    parameter int MEM_SIZE     = 256,
    parameter int RD_LATENCY   = 2,
    parameter int CLR_ON_RESET = 1
) (
    input logic clk,
    input logic reset,
    mem_slave_pipe_if.slave bus
);
    localparam int BYTES = DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH:0] LIMIT = (ADDR_WIDTH + 1)'(MEM_SIZE);
    typedef struct packed {
        logic                  valid;
        logic                  wr;
        logic                  err;
        logic [DATA_WIDTH-1:0] data;
    } entry_t;
    logic [MEM_SIZE-1:0][DATA_WIDTH-1:0] mem;
    entry_t [RD_LATENCY:0] pipe;
    entry_t skid;
    entry_t fresh;
    logic in_range;
    logic accept;
    logic stall;
    assign in_range = {1'b0, bus.addr} < LIMIT;
    assign accept   = bus.req && bus.req_ready;
    assign stall    = pipe[RD_LATENCY].valid && !bus.rsp_ready;
    always_comb begin
        fresh.valid = 1'b1;
        fresh.wr    = bus.wr;
        fresh.err   = !in_range;
        fresh.data  = (!bus.wr && in_range) ? mem[bus.addr] : '0;
    end
    assign bus.slv_rsp = pipe[RD_LATENCY].valid;
    assign bus.rsp_wr  = pipe[RD_LATENCY].wr;
    assign bus.err     = pipe[RD_LATENCY].err;
    assign bus.rdata   = pipe[RD_LATENCY].data;
    always_ff @(posedge clk) begin
        if (reset) begin
            if (CLR_ON_RESET != 0)
                mem <= '0;
        end else if (accept && bus.wr && in_range) begin
            for (int b = 0; b < BYTES; b++)
                if (bus.be[b])
                    mem[bus.addr][8*b +: 8] <= bus.wdata[8*b +: 8];
        end
    end
    // req_ready lags stall by one edge, so one request can land on a stalled edge; it waits in skid
    always_ff @(posedge clk) begin
        if (reset) begin
            pipe          <= '0;
            skid          <= '0;
            bus.req_ready <= 1'b0;
        end else begin
            bus.req_ready <= !stall;
            if (!stall) begin
                pipe <= {pipe[RD_LATENCY-1:0], accept ? fresh : skid};
                skid <= '0;
            end else if (accept) begin
                skid <= fresh;
            end
        end
    end
endmodule

// File: tb/tb_mem_slave_pipe.sv
// tb_mem_slave_pipe: two configurations driven side by side and checked against a queue-based model
module tb_mem_slave_pipe;
    localparam int LAT_A = 2, LAT_B = 1, SIZE_A = 200, SIZE_B = 256;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;
    mem_slave_pipe_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) ia ();
    mem_slave_pipe_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) ib ();
    mem_slave_pipe #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .MEM_SIZE(SIZE_A), .RD_LATENCY(LAT_A), .CLR_ON_RESET(1))
        dut_a (.clk(clk), .reset(reset), .bus(ia));
    mem_slave_pipe #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .MEM_SIZE(SIZE_B), .RD_LATENCY(LAT_B), .CLR_ON_RESET(0))
        dut_b (.clk(clk), .reset(reset), .bus(ib));
    logic [1:0]  req, wr, rsp_ready;
    logic [7:0]  addr [2];
    logic [31:0] wdata [2];
    logic [3:0]  be [2];
    assign ia.req = req[0];
    assign ia.wr = wr[0];
    assign ia.addr = addr[0];
    assign ia.wdata = wdata[0];
    assign ia.be = be[0];
    assign ia.rsp_ready = rsp_ready[0];
    assign ib.req = req[1];
    assign ib.wr = wr[1];
    assign ib.addr = addr[1];
    assign ib.wdata = wdata[1];
    assign ib.be = be[1];
    assign ib.rsp_ready = rsp_ready[1];
    logic [1:0]  o_rr, o_rsp, o_wr, o_err;
    logic [31:0] o_rdata [2];
    assign o_rr  = {ib.req_ready, ia.req_ready};
    assign o_rsp = {ib.slv_rsp, ia.slv_rsp};
    assign o_wr  = {ib.rsp_wr, ia.rsp_wr};
    assign o_err = {ib.err, ia.err};
    assign o_rdata[0] = ia.rdata;
    assign o_rdata[1] = ib.rdata;
    typedef struct {
        logic        wr;
        logic        err;
        logic [31:0] data;
        int          acc;
        bit          seen;
    } exp_t;
    exp_t        fifo [2][64];
    int          head [2];
    int          cnt [2];
    logic [31:0] mmem [2][256];
    int          lat [2] = '{LAT_A, LAT_B};
    int          size [2] = '{SIZE_A, SIZE_B};
    bit          clr [2] = '{1'b1, 1'b0};
    int          last_stall [2];
    int          hold [2];
    logic [34:0] prev_out [2];
    logic [1:0]  took;
    int          cyc, rr_mode, checks, errors;

    task automatic chk(string tag, int k, logic [63:0] got, logic [63:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s dut%0d: observed %h expected %h", tag, k, got, want);
        end
    endtask

    task automatic update(int k, logic rst_now, logic con);
        exp_t e;
        bit in_r;
        if (rst_now) begin
            cnt[k] = 0;
            if (clr[k])
                for (int a = 0; a < 256; a++) mmem[k][a] = '0;
        end else begin
            if (con && cnt[k] > 0) begin
                head[k] = (head[k] + 1) % 64;
                cnt[k]--;
            end
            if (took[k]) begin
                in_r = int'(addr[k]) < size[k];
                if (wr[k] && in_r)
                    for (int b = 0; b < 4; b++)
                        if (be[k][b]) mmem[k][addr[k]][8*b +: 8] = wdata[k][8*b +: 8];
                e.wr = wr[k];
                e.err = !in_r;
                e.data = (!wr[k] && in_r) ? mmem[k][addr[k]] : 32'h0;
                e.acc = cyc;
                e.seen = 1'b0;
                fifo[k][(head[k] + cnt[k]) % 64] = e;
                cnt[k]++;
            end
        end
    endtask

    task automatic check(int k, logic rst_now, logic stl);
        int i;
        chk("req_ready", k, o_rr[k], !rst_now && !stl);
        if (rst_now)
            chk("reset outputs", k, {o_rsp[k], o_wr[k], o_err[k], o_rdata[k]}, 0);
        else if (stl)
            chk("stall hold", k, {o_rsp[k], o_wr[k], o_err[k], o_rdata[k]}, prev_out[k]);
        i = head[k];
        if (o_rsp[k] === 1'b1) begin
            chk("rsp expected", k, cnt[k] > 0, 1);
            if (cnt[k] > 0) begin
                chk("rsp_wr", k, o_wr[k], fifo[k][i].wr);
                chk("err", k, o_err[k], fifo[k][i].err);
                chk("rdata", k, o_rdata[k], fifo[k][i].data);
                if (!fifo[k][i].seen) begin
                    fifo[k][i].seen = 1'b1;
                    if (last_stall[k] < fifo[k][i].acc)
                        chk("latency", k, cyc - fifo[k][i].acc, lat[k]);
                end
            end
        end else if (cnt[k] > 0 && last_stall[k] < fifo[k][i].acc) begin
            chk("slv_rsp late", k, (cyc - fifo[k][i].acc) < lat[k], 1);
        end
    endtask

    task automatic tick();
        logic [1:0] stl, con;
        logic rst_now;
        rst_now = reset;
        for (int k = 0; k < 2; k++) begin
            if (rr_mode == 0)
                rsp_ready[k] = 1'b1;
            else if (rr_mode == 1) begin
                rsp_ready[k] = !(o_rsp[k] === 1'b1 && hold[k] > 0);
                if (!rsp_ready[k]) hold[k]--;
            end else
                rsp_ready[k] = ($urandom_range(3) != 0);
            took[k] = !rst_now && req[k] && (o_rr[k] === 1'b1);
            con[k] = (o_rsp[k] === 1'b1) && rsp_ready[k];
            stl[k] = (o_rsp[k] === 1'b1) && !rsp_ready[k];
            if (stl[k]) last_stall[k] = cyc + 1;
            prev_out[k] = {o_rsp[k], o_wr[k], o_err[k], o_rdata[k]};
        end
        @(posedge clk);
        #1;
        cyc++;
        for (int k = 0; k < 2; k++) begin
            update(k, rst_now, con[k]);
            check(k, rst_now, stl[k]);
        end
    endtask

    task automatic issue(logic [1:0] mask, logic w, logic [7:0] a, logic [31:0] d, logic [3:0] b);
        int n = 0;
        for (int k = 0; k < 2; k++)
            if (mask[k]) begin
                req[k] = 1'b1;
                wr[k] = w;
                addr[k] = a;
                wdata[k] = d;
                be[k] = b;
            end
        while ((req & mask) != 0 && n < 50) begin
            tick();
            n++;
            for (int k = 0; k < 2; k++)
                if (took[k]) req[k] = 1'b0;
        end
        chk("accept wait", 0, (req & mask) == 0, 1);
    endtask

    task automatic drain();
        int n = 0;
        while ((cnt[0] > 0 || cnt[1] > 0) && n < 100) begin
            tick();
            n++;
        end
        chk("drain", 0, cnt[0] + cnt[1], 0);
    endtask

    initial begin
        req = '0;
        wr = '0;
        rsp_ready = '1;
        for (int k = 0; k < 2; k++) begin
            addr[k] = '0;
            wdata[k] = '0;
            be[k] = '0;
            head[k] = 0;
            cnt[k] = 0;
            last_stall[k] = 0;
            hold[k] = 0;
        end
        cyc = 0;
        rr_mode = 0;
        checks = 0;
        errors = 0;
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        tick();
        issue(2'b01, 1'b0, 8'h10, 32'h0, 4'h0);
        drain();
        for (int a = 0; a < 256; a++)
            issue(2'b11, 1'b1, 8'(a), $urandom, 4'hF);
        drain();
        issue(2'b11, 1'b1, 8'h05, 32'hDEADBEEF, 4'hF);
        issue(2'b11, 1'b1, 8'h05, 32'h000000AA, 4'h1);
        issue(2'b11, 1'b0, 8'h05, 32'h0, 4'h0);
        issue(2'b11, 1'b1, 8'h06, 32'hFFFFFFFF, 4'h0);
        issue(2'b11, 1'b0, 8'h06, 32'h0, 4'h0);
        drain();
        issue(2'b11, 1'b1, 8'h20, 32'h12345678, 4'hF);
        issue(2'b11, 1'b0, 8'h20, 32'h0, 4'h0);
        drain();
        rr_mode = 1;
        hold[0] = 3;
        hold[1] = 3;
        for (int a = 0; a < 4; a++)
            issue(2'b11, 1'b0, 8'(a), 32'h0, 4'h0);
        drain();
        rr_mode = 0;
        issue(2'b11, 1'b1, 8'hC8, $urandom, 4'hF);
        issue(2'b11, 1'b0, 8'hC8, 32'h0, 4'h0);
        issue(2'b11, 1'b0, 8'hC7, 32'h0, 4'h0);
        issue(2'b11, 1'b0, 8'hFF, 32'h0, 4'h0);
        issue(2'b11, 1'b0, 8'h00, 32'h0, 4'h0);
        drain();
        issue(2'b11, 1'b0, 8'h05, 32'h0, 4'h0);
        issue(2'b11, 1'b0, 8'h20, 32'h0, 4'h0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        repeat (5) tick();
        issue(2'b11, 1'b0, 8'h20, 32'h0, 4'h0);
        issue(2'b11, 1'b0, 8'h05, 32'h0, 4'h0);
        drain();
        rr_mode = 2;
        for (int n = 0; n < 400; n++) begin
            for (int k = 0; k < 2; k++)
                if (!req[k] && $urandom_range(9) < 6) begin
                    req[k] = 1'b1;
                    wr[k] = 1'($urandom_range(1));
                    addr[k] = 8'($urandom_range(255));
                    wdata[k] = $urandom;
                    be[k] = 4'($urandom_range(15));
                end
            reset = ($urandom_range(99) == 0);
            tick();
            for (int k = 0; k < 2; k++)
                if (took[k]) req[k] = 1'b0;
        end
        reset = 1'b0;
        req = '0;
        rr_mode = 0;
        drain();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_slave_pipe.md
Name: mem_slave_pipe

Overview:
- Parametrised synchronous memory slave; next generation of the single-port wr/addr/wdata/rdata/slv_rsp memory model.
- Adds request/response handshakes, byte enables, a configurable pipelined read latency, response back-pressure and out-of-range error reporting.
- Sits as the DUT behind the memory interface. The UVM driver issues requests, the monitors sample both channels, and the RAL backdoor reaches the `mem` array by hierarchical path.

Parameters:
- ADDR_WIDTH, 8, address bits.
- DATA_WIDTH, 32, data bits; must be a multiple of 8.
- MEM_SIZE, 256, number of words; legal addresses are 0..MEM_SIZE-1, and MEM_SIZE <= 2**ADDR_WIDTH.
- RD_LATENCY, 2, cycles from request accept to response; legal range 1..8.
- CLR_ON_RESET, 1, 1 = reset zeroes all memory words; 0 = memory keeps its contents through reset.

Ports:
- clk  input  1  clock; all logic on posedge.
- reset  input  1  synchronous, active-high reset.
- req  input  1  request valid.
- req_ready  output  1  slave can accept a request.
- wr  input  1  1 = write, 0 = read.
- addr  input  ADDR_WIDTH  word address.
- wdata  input  DATA_WIDTH  write data.
- be  input  DATA_WIDTH/8  byte enables for writes; bit i covers wdata[8i+7:8i].
- slv_rsp  output  1  response valid.
- rsp_ready  input  1  master accepts the response.
- rsp_wr  output  1  type of the request this response belongs to.
- rdata  output  DATA_WIDTH  read data; 0 for write and error responses.
- err  output  1  response belongs to an out-of-range address.

Behaviour:
- Reset (clk edge with reset=1):
  - slv_rsp=0, rsp_wr=0, rdata=0, err=0, req_ready=0.
  - All pipeline stages are invalidated, including in-flight requests; those are dropped with no response.
  - If CLR_ON_RESET=1, every mem word becomes 0.
  - req_ready rises on the first edge after reset deasserts.
- Accept:
  - A request is accepted on an edge where req && req_ready.
  - req_ready is registered: req_ready = !reset && !stall, with stall as defined under Back-pressure.
  - When not stalled, one request is accepted per cycle.
- Write:
  - Applied to mem at the accept edge, only for bytes with be[i]=1; other bytes are unchanged.
  - be=0 still produces a normal response with no memory change.
- Read:
  - mem is sampled at the accept edge, after any write committed at an earlier edge.
  - A read accepted the cycle after a write to the same address returns the new data.
- Out of range (addr >= MEM_SIZE):
  - No memory update; the response has err=1 and rdata=0.
- Pipeline:
  - RD_LATENCY-stage shift register carrying {valid, wr, err, data}.
  - Responses are strictly in order; writes travel the pipeline too, so write and read responses never reorder.
  - slv_rsp is asserted exactly RD_LATENCY edges after the accept edge, absent stalls.
- Back-pressure:
  - stall = slv_rsp && !rsp_ready.
  - While stalled, every stage holds its contents and slv_rsp/rsp_wr/rdata/err stay stable.
  - req_ready drops on the next edge; no request is accepted while req_ready=0.
  - A request presented while req_ready=0 is ignored and must be held by the master.
- Response handoff:
  - A response is consumed on an edge where slv_rsp && rsp_ready.
  - Back-to-back responses with rsp_ready held high stream at 1 per cycle.
- Bubbles: empty stages propagate normally; they never stall the pipeline and never raise slv_rsp.
- Reset mid-stall: reset wins over the stall; all stages are cleared.

Test Plan:
- Reset with CLR_ON_RESET=1, then read addr 0x10 -> slv_rsp exactly 2 cycles after accept, rdata=0x00000000, err=0.
- Write 0xDEADBEEF to addr 0x05 with be=4'b1111, then write 0x000000AA with be=4'b0001, then read 0x05 -> responses in order wr, wr, rd; rdata=0xDEADBEAA.
- Write 0x12345678 to addr 0x20, read 0x20 on the next cycle with RD_LATENCY=1 -> read response 1 cycle after its accept, rdata=0x12345678.
- Stream 4 reads (0x00..0x03) with rsp_ready=0 from the first response for 3 cycles:
  - slv_rsp/rdata hold for addr 0x00 and req_ready=0 during the stall.
  - After rsp_ready=1, 4 responses come out in order with no loss or duplication.
- MEM_SIZE=200: write to addr 0xC8, then read 0xC8 -> both responses have err=1; the read returns rdata=0; mem[0..199] is unchanged.
- Issue 2 reads, assert reset for 1 cycle mid-flight -> no response for either read.
  - With CLR_ON_RESET=0, a previously written word reads back intact after reset.
